// File: rtl/ahb_lite_manager.sv
// AHB-Lite manager: turns a command/response interface into pipelined single transfers,
// with wait-state and two-cycle ERROR handling plus byte-lane steering.
module ahb_lite_manager (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [3:0]  cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        hsel,
  output logic [3:0]  haddr,
  output logic [1:0]  hsize,
  output logic        hwrite,
  output logic [1:0]  htrans,
  output logic [2:0]  hburst,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp
);

  typedef enum logic {ST_RUN, ST_ERR2} state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  function automatic logic [31:0] lane_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 32'h0000_00FF;
      2'd1:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // A stage: haddr/hsize/hwrite double as its address fields so they hold when A empties
  state_t      st, st_n;
  logic        a_valid, a_valid_n;
  logic [31:0] a_wdata, a_wdata_n;
  logic        d_valid, d_valid_n;
  logic        d_write, d_write_n;
  logic [1:0]  d_lane, d_lane_n;
  logic [1:0]  d_size, d_size_n;
  logic [3:0]  haddr_n;
  logic [1:0]  hsize_n, htrans_n;
  logic        hwrite_n, hsel_n;
  logic [31:0] hwdata_n, rsp_rdata_n;
  logic        rsp_valid_n, rsp_err_n;

  logic legal, err_first, a_adv, d_done, accept;

  assign hburst = 3'b000;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latches).
  always_comb begin
    legal = (cmd_size != 2'd3) &&
            !(cmd_size == 2'd1 && cmd_addr[0]) &&
            !(cmd_size == 2'd2 && cmd_addr[1:0] != 2'b00);

    err_first = (st == ST_RUN) && d_valid && hresp && !hready;
    a_adv     = a_valid && hready && (st == ST_RUN);
    d_done    = d_valid && hready;

    if (st != ST_RUN || err_first)
      cmd_ready = 1'b0;
    else if (legal)
      cmd_ready = !a_valid || a_adv;
    else
      cmd_ready = !a_valid && !d_valid;
    accept = cmd_valid && cmd_ready;

    a_valid_n = a_valid;
    a_wdata_n = a_wdata;
    haddr_n   = haddr;
    hsize_n   = hsize;
    hwrite_n  = hwrite;
    if (a_adv)
      a_valid_n = 1'b0;
    if (accept && legal) begin
      a_valid_n = 1'b1;
      a_wdata_n = (cmd_wdata & lane_mask(cmd_size)) << {cmd_addr[1:0], 3'b000};
      haddr_n   = cmd_addr;
      hsize_n   = cmd_size;
      hwrite_n  = cmd_write;
    end

    d_valid_n = d_valid;
    d_write_n = d_write;
    d_lane_n  = d_lane;
    d_size_n  = d_size;
    hwdata_n  = hwdata;
    if (a_adv) begin
      d_valid_n = 1'b1;
      d_write_n = hwrite;
      d_lane_n  = haddr[1:0];
      d_size_n  = hsize;
      hwdata_n  = hwrite ? a_wdata : 32'h0;
    end else if (d_done) begin
      d_valid_n = 1'b0;
      hwdata_n  = 32'h0;
    end

    st_n = st;
    if (err_first)
      st_n = ST_ERR2;
    else if (st == ST_ERR2 && hready)
      st_n = ST_RUN;

    // During the second error cycle A stays loaded but is withheld from the bus
    htrans_n = (a_valid_n && st_n == ST_RUN) ? HTRANS_NONSEQ : HTRANS_IDLE;
    hsel_n   = a_valid_n || d_valid_n;

    rsp_valid_n = d_done || (accept && !legal);
    rsp_err_n   = d_done ? hresp : (accept && !legal);
    rsp_rdata_n = (d_done && !d_write && !hresp)
                ? ((hrdata >> {d_lane, 3'b000}) & lane_mask(d_size)) : 32'h0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ST_RUN;
      a_valid   <= 1'b0;
      a_wdata   <= 32'h0;
      d_valid   <= 1'b0;
      d_write   <= 1'b0;
      d_lane    <= 2'b00;
      d_size    <= 2'b00;
      haddr     <= 4'h0;
      hsize     <= 2'b00;
      hwrite    <= 1'b0;
      htrans    <= HTRANS_IDLE;
      hsel      <= 1'b0;
      hwdata    <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
    end else begin
      st        <= st_n;
      a_valid   <= a_valid_n;
      a_wdata   <= a_wdata_n;
      d_valid   <= d_valid_n;
      d_write   <= d_write_n;
      d_lane    <= d_lane_n;
      d_size    <= d_size_n;
      haddr     <= haddr_n;
      hsize     <= hsize_n;
      hwrite    <= hwrite_n;
      htrans    <= htrans_n;
      hsel      <= hsel_n;
      hwdata    <= hwdata_n;
      rsp_valid <= rsp_valid_n;
      rsp_err   <= rsp_err_n;
      rsp_rdata <= rsp_rdata_n;
    end
  end

endmodule

// File: tb/tb_ahb_lite_manager.sv
// Directed bench for ahb_lite_manager: each cycle's stimulus and expected outputs are hand-derived.
module tb_ahb_lite_manager;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        hsel, hwrite;
  logic [3:0]  haddr;
  logic [1:0]  hsize, htrans;
  logic [2:0]  hburst;
  logic [31:0] hwdata, hrdata;
  logic        hready, hresp;

  int checks = 0;
  int errors = 0;

  ahb_lite_manager dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .hsel(hsel), .haddr(haddr), .hsize(hsize), .hwrite(hwrite),
    .htrans(htrans), .hburst(hburst), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs checked 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic wr, input logic [3:0] addr, input logic [1:0] size,
                     input logic [31:0] wdata);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_size  = size;
    cmd_wdata = wdata;
    #1;
  endtask

  task automatic no_cmd();
    cmd_valid = 1'b0;
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic e, input logic [31:0] d);
    check({tag, "_rsp_valid"}, {31'h0, rsp_valid}, {31'h0, v});
    check({tag, "_rsp_err"},   {31'h0, rsp_err},   {31'h0, e});
    check({tag, "_rsp_rdata"}, rsp_rdata, d);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 4'h0; cmd_size = 2'd0;
    cmd_wdata = 32'h0; hrdata = 32'h0; hready = 1'b1; hresp = 1'b0;
    #1;
    tick(); tick();
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_hsel",   {31'h0, hsel}, 32'h0);
    check("rst_htrans", {30'h0, htrans}, 32'h0);
    check("rst_haddr",  {28'h0, haddr}, 32'h0);
    check("rst_hburst", {29'h0, hburst}, 32'h0);
    check("rst_hwdata", hwdata, 32'h0);
    check("rst_ready",  {31'h0, cmd_ready}, 32'h1);
    check_rsp("rst", 1'b0, 1'b0, 32'h0);

    // Byte write addr 1: NONSEQ at N+1, steered data at N+2, response at N+3
    cmd(1'b1, 4'h1, 2'd0, 32'h0000_00A5);
    check("bw_ready", {31'h0, cmd_ready}, 32'h1);
    tick(); no_cmd();
    check("bw_htrans", {30'h0, htrans}, 32'h2);
    check("bw_haddr",  {28'h0, haddr}, 32'h1);
    check("bw_hwrite", {31'h0, hwrite}, 32'h1);
    check("bw_hsel",   {31'h0, hsel}, 32'h1);
    tick();
    check("bw_hwdata",  hwdata, 32'h0000_A500);
    check("bw_htrans2", {30'h0, htrans}, 32'h0);
    check("bw_norsp",   {31'h0, rsp_valid}, 32'h0);
    tick();
    check_rsp("bw", 1'b1, 1'b0, 32'h0);
    tick();
    check("bw_idle_rsp",  {31'h0, rsp_valid}, 32'h0);
    check("bw_idle_hsel", {31'h0, hsel}, 32'h0);
    check("bw_idle_wd",   hwdata, 32'h0);

    // Word read addr 4, then halfword read addr 2 pipelined behind it
    cmd(1'b0, 4'h4, 2'd2, 32'h0);
    tick();
    cmd(1'b0, 4'h2, 2'd1, 32'h0);
    check("rd_ready_pipe", {31'h0, cmd_ready}, 32'h1);
    check("rd_haddr1", {28'h0, haddr}, 32'h4);
    check("rd_hsize1", {30'h0, hsize}, 32'h2);
    tick(); no_cmd();
    hrdata = 32'h1122_3344;
    check("rd_haddr2",  {28'h0, haddr}, 32'h2);
    check("rd_htrans2", {30'h0, htrans}, 32'h2);
    tick();
    check_rsp("rd_word", 1'b1, 1'b0, 32'h1122_3344);
    tick();
    check_rsp("rd_half", 1'b1, 1'b0, 32'h0000_1122);
    tick();
    check("rd_done", {31'h0, rsp_valid}, 32'h0);

    // Back-to-back write/read with two wait states on the write data phase
    cmd(1'b1, 4'h0, 2'd2, 32'hDEAD_BEEF);
    tick();
    cmd(1'b0, 4'hC, 2'd0, 32'h0);
    tick(); no_cmd();
    hready = 1'b0;
    #1;
    check("bb_hwdata_w1", hwdata, 32'hDEAD_BEEF);
    check("bb_haddr_w1",  {28'h0, haddr}, 32'hC);
    check("bb_ready_w1",  {31'h0, cmd_ready}, 32'h0);
    tick();
    check("bb_hwdata_w2", hwdata, 32'hDEAD_BEEF);
    check("bb_haddr_w2",  {28'h0, haddr}, 32'hC);
    check("bb_htrans_w2", {30'h0, htrans}, 32'h2);
    check("bb_norsp_w2",  {31'h0, rsp_valid}, 32'h0);
    tick();
    hready = 1'b1;
    check("bb_norsp_w3", {31'h0, rsp_valid}, 32'h0);
    tick();
    hrdata = 32'hCAFE_BA77;
    check_rsp("bb_write", 1'b1, 1'b0, 32'h0);
    check("bb_hwdata_rd", hwdata, 32'h0);
    tick();
    check_rsp("bb_read", 1'b1, 1'b0, 32'h0000_0077);
    tick();

    // Two-cycle ERROR on a byte write to addr 9 with a word read to addr 4 behind it
    cmd(1'b1, 4'h9, 2'd0, 32'h0000_005A);
    tick();
    cmd(1'b0, 4'h4, 2'd2, 32'h0);
    tick(); no_cmd();
    hresp = 1'b1; hready = 1'b0;
    #1;
    check("er_hwdata", hwdata, 32'h0000_5A00);
    check("er_c1_htrans", {30'h0, htrans}, 32'h2);
    check("er_c1_ready", {31'h0, cmd_ready}, 32'h0);
    tick();
    hready = 1'b1;
    #1;
    check("er_c2_htrans", {30'h0, htrans}, 32'h0);
    check("er_c2_hsel",   {31'h0, hsel}, 32'h1);
    check("er_c2_ready",  {31'h0, cmd_ready}, 32'h0);
    tick();
    hresp = 1'b0;
    check_rsp("er_write", 1'b1, 1'b1, 32'h0);
    check("er_reissue_htrans", {30'h0, htrans}, 32'h2);
    check("er_reissue_haddr",  {28'h0, haddr}, 32'h4);
    check("er_reissue_hwrite", {31'h0, hwrite}, 32'h0);
    tick();
    hrdata = 32'h0BAD_F00D;
    check("er_rd_dphase_rsp", {31'h0, rsp_valid}, 32'h0);
    tick();
    check_rsp("er_read", 1'b1, 1'b0, 32'h0BAD_F00D);
    tick();

    // Local rejects: misaligned word read, then size 3
    cmd(1'b0, 4'h2, 2'd2, 32'h0);
    check("rj1_ready", {31'h0, cmd_ready}, 32'h1);
    tick();
    cmd(1'b0, 4'h0, 2'd3, 32'h0);
    check_rsp("rj1", 1'b1, 1'b1, 32'h0);
    check("rj1_htrans", {30'h0, htrans}, 32'h0);
    check("rj2_ready", {31'h0, cmd_ready}, 32'h1);
    tick(); no_cmd();
    check_rsp("rj2", 1'b1, 1'b1, 32'h0);
    check("rj2_htrans", {30'h0, htrans}, 32'h0);
    check("rj2_hsel",   {31'h0, hsel}, 32'h0);
    tick();
    check("rj_done", {31'h0, rsp_valid}, 32'h0);
    check("rj_htrans", {30'h0, htrans}, 32'h0);

    // Reset during the data phase of a word write
    cmd(1'b1, 4'h0, 2'd2, 32'h1234_5678);
    tick(); no_cmd();
    tick();
    check("rs_hwdata_pre", hwdata, 32'h1234_5678);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rs_hsel",   {31'h0, hsel}, 32'h0);
    check("rs_htrans", {30'h0, htrans}, 32'h0);
    check("rs_haddr",  {28'h0, haddr}, 32'h0);
    check("rs_hwdata", hwdata, 32'h0);
    check("rs_ready",  {31'h0, cmd_ready}, 32'h1);
    check_rsp("rs", 1'b0, 1'b0, 32'h0);
    tick();
    check("rs_norsp", {31'h0, rsp_valid}, 32'h0);

    // Normal read after reset
    cmd(1'b0, 4'h8, 2'd2, 32'h0);
    tick(); no_cmd();
    check("pr_htrans", {30'h0, htrans}, 32'h2);
    check("pr_haddr",  {28'h0, haddr}, 32'h8);
    tick();
    hrdata = 32'h8765_4321;
    tick();
    check_rsp("pr", 1'b1, 1'b0, 32'h8765_4321);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
